ysyx_23060240_mem_arbiter: RTL and testbench
============================================

# ysyx_23060240_mem_arbiter

Two-master, one-slave memory arbiter that shares the single memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write) of the ysyx_23060240 core. Grants round-robin, keeps one transaction outstanding, and returns each response to its owner. Enforces a response timeout so a hung slave cannot stall the core forever. Sits between IFU/LSU and the memory/bus bridge, replacing their direct memory connections.

## Interface

- TIMEOUT, 1024: cycles allowed from grant to slave response; 0 disables the timeout; range 0..65535.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-low.
- ifu_req_valid / ifu_req_ready  in / out  1 / 1  IFU request handshake.
- ifu_addr  in  32  IFU fetch address.
- ifu_resp_valid / ifu_resp_ready  out / in  1 / 1  IFU response handshake.
- ifu_rdata  out  32  fetched word.
- ifu_resp_err  out  1  error flag, qualified by ifu_resp_valid.
- lsu_req_valid / lsu_req_ready  in / out  1 / 1  LSU request handshake.
- lsu_addr / lsu_wdata  in  32 / 32  address, write data.
- lsu_wen / lsu_wmask  in  1 / 4  write enable, byte strobes.
- lsu_resp_valid / lsu_resp_ready  out / in  1 / 1  LSU response handshake.
- lsu_rdata / lsu_resp_err  out  32 / 1  read data, error flag.
- mem_req_valid / mem_req_ready  out / in  1 / 1  slave request handshake.
- mem_addr / mem_wdata  out  32 / 32  registered request address/data.
- mem_wen / mem_wmask  out  1 / 4  registered write enable, strobes (IFU: wen=0, wmask=0).
- mem_resp_valid / mem_resp_ready  in / out  1 / 1  slave response handshake.
- mem_rdata / mem_resp_err  in  32 / 1  slave read data, error.
- owner  out  2  00 none, 01 IFU, 10 LSU.

## Operation

- States: IDLE, REQ, WAIT, ERR.
- IDLE: selects a master from the valids. If only one is valid, select it. If both are valid, select the one not granted last (last_grant). Assert req_ready only to the selected master (combinational). On handshake: capture addr/wdata/wen/wmask, set owner, update last_grant, clear counter, go to REQ.
- REQ: mem_req_valid=1 with captured fields held stable. On mem_req_ready go to WAIT.
- WAIT: route mem_resp_valid/rdata/err combinationally to the owner's resp port; mem_resp_ready = owner's resp_ready. On mem_resp_valid & mem_resp_ready: owner←00, go to IDLE.
- Timeout (TIMEOUT≠0): 16-bit counter increments each cycle in REQ and WAIT. When counter==TIMEOUT-1 and the exiting handshake did not occur this cycle, go to ERR. Leaving REQ drops mem_req_valid.
- ERR: owner's resp_valid=1, resp_err=1, rdata=32'h0 until owner resp_ready, then IDLE with owner←00.
- mem_resp_ready=1 in IDLE, REQ and ERR, so a late or spurious slave response is discarded and never forwarded.
- Non-owner resp_valid is always 0, and the non-owner's rdata is 32'h0.
- Reset values: state IDLE; owner 00; last_grant IFU (LSU wins the first tie); counter 0; all req_ready, resp_valid, resp_err and mem_req_valid 0. Captured data registers are 0.

## Timing

- Master handshake at cycle N → mem_req_valid at N+1 (one registered cycle).
- Slave response at cycle M is seen by the owner at cycle M (zero-latency pass-through).
- Minimum turnaround: handshake N, mem_req_ready at N+1, response at N+2, next grant can handshake at N+3.
- A single master requesting back-to-back is re-granted every turnaround. Round-robin only matters on ties.
- A master dropping req_valid before its handshake is never granted.
- Reset asserted mid-transaction returns to IDLE on the next edge. Any outstanding slave response after reset is discarded by mem_resp_ready=1.

## Test plan

- Reset: rst=0 for 2 cycles → owner=00, mem_req_valid=0, both req_ready=0, both resp_valid=0.
- Single IFU read of addr 0x8000_0000: slave readies at once and returns 0x0000_0413 one cycle later → ifu_rdata=0x0000_0413, err=0, mem_wen=0, lsu_resp_valid never 1.
- Simultaneous IFU and LSU requests, three rounds: both valids held → grant order LSU, IFU, LSU; LSU store 0x8000_0100 / 0xDEADBEEF / mask 4'b1111 appears unchanged on mem_*.
- Backpressure: slave response held valid while lsu_resp_ready=0 for 3 cycles → mem_resp_ready=0 for those cycles. The response is consumed only in the cycle lsu_resp_ready=1, and the state stays WAIT until then.
- Timeout with TIMEOUT=8: slave never responds → owner sees resp_valid=1, resp_err=1, rdata=0 at cycle 8 after grant. A late mem_resp_valid afterwards is dropped, and the next request still completes normally.
- Reset during WAIT: rst=0 one cycle → IDLE, owner=00. A subsequent mem_resp_valid produces no resp_valid on either master.

Source files
------------

// File: rtl/ysyx_23060240_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU (read-only) and LSU.
// One transaction in flight; responses are routed to the owner, with a response timeout.
module ysyx_23060240_mem_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,
  output logic        ifu_resp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic        lsu_wen,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,
  output logic        lsu_resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp_err,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ERR} state_e;

  localparam logic [1:0]  OWN_NONE = 2'b00;
  localparam logic [1:0]  OWN_IFU  = 2'b01;
  localparam logic [1:0]  OWN_LSU  = 2'b10;
  localparam bit          TMO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TMO_LAST = TMO_EN ? 16'(TIMEOUT - 1) : 16'd0;

  state_e      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic        last_lsu_q, last_lsu_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic [3:0]  wmask_q, wmask_d;

  logic        pick_lsu, pick_ifu, tmo_hit, owner_resp_ready;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_NONE;
      last_lsu_q <= 1'b0;
      cnt_q      <= 16'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wen_q      <= 1'b0;
      wmask_q    <= 4'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_lsu_q <= last_lsu_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wen_q      <= wen_d;
      wmask_q    <= wmask_d;
    end
  end

  // On a tie the master that did not win last time is picked.
  assign pick_lsu         = lsu_req_valid && (!ifu_req_valid || !last_lsu_q);
  assign pick_ifu         = ifu_req_valid && !pick_lsu;
  assign tmo_hit          = TMO_EN && (cnt_q == TMO_LAST);
  assign owner_resp_ready = (owner_q == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_lsu_d     = last_lsu_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wen_d          = wen_q;
    wmask_d        = wmask_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_resp_ready = 1'b1;
    resp_valid     = 1'b0;
    resp_err       = 1'b0;
    resp_rdata     = 32'd0;

    unique case (state_q)
      S_IDLE: begin
        ifu_req_ready = rst && pick_ifu;
        lsu_req_ready = rst && pick_lsu;
        if (pick_lsu) begin
          addr_d     = lsu_addr;
          wdata_d    = lsu_wdata;
          wen_d      = lsu_wen;
          wmask_d    = lsu_wmask;
          owner_d    = OWN_LSU;
          last_lsu_d = 1'b1;
          cnt_d      = 16'd0;
          state_d    = S_REQ;
        end else if (pick_ifu) begin
          addr_d     = ifu_addr;
          wdata_d    = 32'd0;
          wen_d      = 1'b0;
          wmask_d    = 4'd0;
          owner_d    = OWN_IFU;
          last_lsu_d = 1'b0;
          cnt_d      = 16'd0;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (mem_req_ready)  state_d = S_WAIT;
        else if (tmo_hit)   state_d = S_ERR;
      end
      S_WAIT: begin
        cnt_d          = cnt_q + 16'd1;
        mem_resp_ready = owner_resp_ready;
        resp_valid     = mem_resp_valid;
        resp_err       = mem_resp_err;
        resp_rdata     = mem_rdata;
        if (mem_resp_valid && owner_resp_ready) begin
          owner_d = OWN_NONE;
          state_d = S_IDLE;
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        if (owner_resp_ready) begin
          owner_d = OWN_NONE;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Only the owner ever sees a response; the other master gets zeros.
  assign ifu_resp_valid = (owner_q == OWN_IFU) && resp_valid;
  assign ifu_resp_err   = (owner_q == OWN_IFU) && resp_err;
  assign ifu_rdata      = (owner_q == OWN_IFU) ? resp_rdata : 32'd0;
  assign lsu_resp_valid = (owner_q == OWN_LSU) && resp_valid;
  assign lsu_resp_err   = (owner_q == OWN_LSU) && resp_err;
  assign lsu_rdata      = (owner_q == OWN_LSU) ? resp_rdata : 32'd0;

  assign mem_req_valid = (state_q == S_REQ);
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wen       = wen_q;
  assign mem_wmask     = wmask_q;
  assign owner         = owner_q;

endmodule

// File: tb/tb_ysyx_23060240_mem_arbiter.sv
// Directed bench for ysyx_23060240_mem_arbiter, built with TIMEOUT=8.
module tb_ysyx_23060240_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready, mem_resp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic [1:0]  owner;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_23060240_mem_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wen(lsu_wen), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
    .owner(owner)
  );

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (owner !== 2'b00 || mem_req_valid !== 1'b0 || ifu_req_ready !== 1'b0 ||
        lsu_req_ready !== 1'b0 || ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: owner=%b mrv=%b irr=%b lrr=%b irv=%b lrv=%b required 00 0 0 0 0 0",
               owner, mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid);
    end
    rst = 1'b1;
    $display("txn reset done");
  endtask

  task automatic test_ifu_read();
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0000;
    #1;
    checks++;
    if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL ifu_grant_ready: ifu=%b lsu=%b required 1 0", ifu_req_ready, lsu_req_ready);
    end
    @(negedge clk);
    ifu_req_valid = 1'b0;
    checks++;
    if (owner !== 2'b01 || mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0000 ||
        mem_wen !== 1'b0 || mem_wmask !== 4'b0000) begin
      failures++;
      $display("FAIL ifu_mem_req: owner=%b valid=%b addr=%h wen=%b wmask=%b required 01 1 80000000 0 0000",
               owner, mem_req_valid, mem_addr, mem_wen, mem_wmask);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata = 32'h0000_0413;
    mem_resp_err = 1'b0;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0 || ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h0000_0413 ||
        ifu_resp_err !== 1'b0 || lsu_resp_valid !== 1'b0 || lsu_rdata !== 32'h0) begin
      failures++;
      $display("FAIL ifu_resp: mrv=%b irv=%b rdata=%h err=%b lrv=%b lrdata=%h required 0 1 00000413 0 0 00000000",
               mem_req_valid, ifu_resp_valid, ifu_rdata, ifu_resp_err, lsu_resp_valid, lsu_rdata);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    checks++;
    if (owner !== 2'b00 || lsu_resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL ifu_release: owner=%b lrv=%b required 00 0", owner, lsu_resp_valid);
    end
    $display("txn ifu read addr=80000000 rdata=%h", ifu_rdata);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_own [3];
    exp_own[0] = 2'b10; exp_own[1] = 2'b01; exp_own[2] = 2'b10;
    ifu_req_valid = 1'b1; ifu_addr  = 32'h8000_0004;
    lsu_req_valid = 1'b1; lsu_addr  = 32'h8000_0100;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wen = 1'b1; lsu_wmask = 4'b1111;
    for (int r = 0; r < 3; r++) begin
      #1;
      checks++;
      if (lsu_req_ready !== exp_own[r][1] || ifu_req_ready !== exp_own[r][0]) begin
        failures++;
        $display("FAIL rr_ready_%0d: lsu=%b ifu=%b required %b %b",
                 r, lsu_req_ready, ifu_req_ready, exp_own[r][1], exp_own[r][0]);
      end
      @(negedge clk);
      checks++;
      if (owner !== exp_own[r] || mem_req_valid !== 1'b1) begin
        failures++;
        $display("FAIL rr_owner_%0d: owner=%b mrv=%b required %b 1", r, owner, mem_req_valid, exp_own[r]);
      end
      checks++;
      if (exp_own[r] == 2'b10) begin
        if (mem_addr !== 32'h8000_0100 || mem_wdata !== 32'hDEAD_BEEF ||
            mem_wen !== 1'b1 || mem_wmask !== 4'b1111) begin
          failures++;
          $display("FAIL rr_lsu_fields_%0d: addr=%h wdata=%h wen=%b wmask=%b required 80000100 deadbeef 1 1111",
                   r, mem_addr, mem_wdata, mem_wen, mem_wmask);
        end
      end else begin
        if (mem_addr !== 32'h8000_0004 || mem_wen !== 1'b0 || mem_wmask !== 4'b0000) begin
          failures++;
          $display("FAIL rr_ifu_fields_%0d: addr=%h wen=%b wmask=%b required 80000004 0 0000",
                   r, mem_addr, mem_wen, mem_wmask);
        end
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata = 32'h1111_0000 + 32'(r);
      #1;
      checks++;
      if (lsu_resp_valid !== exp_own[r][1] || ifu_resp_valid !== exp_own[r][0]) begin
        failures++;
        $display("FAIL rr_resp_route_%0d: lrv=%b irv=%b required %b %b",
                 r, lsu_resp_valid, ifu_resp_valid, exp_own[r][1], exp_own[r][0]);
      end
      @(negedge clk);
      mem_resp_valid = 1'b0;
      $display("txn round %0d owner=%b addr=%h", r, exp_own[r], mem_addr);
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_wen = 1'b0;
  endtask

  task automatic test_backpressure();
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b0; lsu_wmask = 4'b0000;
    @(negedge clk);
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata = 32'h1234_5678;
    lsu_resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (mem_resp_ready !== 1'b0 || lsu_resp_valid !== 1'b1 || owner !== 2'b10 ||
          lsu_rdata !== 32'h1234_5678) begin
        failures++;
        $display("FAIL bp_hold_%0d: mrr=%b lrv=%b owner=%b rdata=%h required 0 1 10 12345678",
                 c, mem_resp_ready, lsu_resp_valid, owner, lsu_rdata);
      end
      @(negedge clk);
    end
    lsu_resp_ready = 1'b1;
    #1;
    checks++;
    if (mem_resp_ready !== 1'b1 || lsu_resp_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_consume: mrr=%b lrv=%b required 1 1", mem_resp_ready, lsu_resp_valid);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    checks++;
    if (owner !== 2'b00) begin
      failures++;
      $display("FAIL bp_release: owner=%b required 00", owner);
    end
    $display("txn lsu read under backpressure addr=80000200");
  endtask

  task automatic test_timeout();
    int early = 0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0300;
    ifu_resp_ready = 1'b0;
    @(negedge clk);
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    // Eight cycles in REQ/WAIT with counter 0..7; the error appears on the ninth.
    for (int c = 1; c <= 8; c++) begin
      if (ifu_resp_valid !== 1'b0) early++;
      @(negedge clk);
      mem_req_ready = 1'b0;
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL tmo_early: premature resp_valid cycles=%0d required 0", early);
    end
    checks++;
    if (ifu_resp_valid !== 1'b1 || ifu_resp_err !== 1'b1 || ifu_rdata !== 32'h0 || lsu_resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL tmo_err: irv=%b err=%b rdata=%h lrv=%b required 1 1 00000000 0",
               ifu_resp_valid, ifu_resp_err, ifu_rdata, lsu_resp_valid);
    end
    @(negedge clk);
    checks++;
    if (ifu_resp_valid !== 1'b1 || owner !== 2'b01) begin
      failures++;
      $display("FAIL tmo_err_hold: irv=%b owner=%b required 1 01", ifu_resp_valid, owner);
    end
    ifu_resp_ready = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata = 32'h0000_0BAD;
    #1;
    checks++;
    if (mem_resp_ready !== 1'b1 || ifu_rdata !== 32'h0 || ifu_resp_err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_late_drop: mrr=%b rdata=%h err=%b required 1 00000000 1",
               mem_resp_ready, ifu_rdata, ifu_resp_err);
    end
    @(negedge clk);
    checks++;
    if (owner !== 2'b00 || ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 || mem_resp_ready !== 1'b1) begin
      failures++;
      $display("FAIL tmo_idle_spurious: owner=%b irv=%b lrv=%b mrr=%b required 00 0 0 1",
               owner, ifu_resp_valid, lsu_resp_valid, mem_resp_ready);
    end
    mem_resp_valid = 1'b0;
    $display("txn ifu timeout addr=80000300");
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0304;
    @(negedge clk);
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata = 32'h0010_0073;
    #1;
    checks++;
    if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h0010_0073 || ifu_resp_err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_recover: irv=%b rdata=%h err=%b required 1 00100073 0",
               ifu_resp_valid, ifu_rdata, ifu_resp_err);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    $display("txn ifu read after timeout addr=80000304");
  endtask

  task automatic test_reset_wait();
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0400; lsu_wen = 1'b0; lsu_wmask = 4'b0000;
    @(negedge clk);
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (owner !== 2'b00 || mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstwait_idle: owner=%b mrv=%b required 00 0", owner, mem_req_valid);
    end
    mem_resp_valid = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 || mem_resp_ready !== 1'b1 || lsu_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rstwait_drop: irv=%b lrv=%b mrr=%b lrdata=%h required 0 0 1 00000000",
               ifu_resp_valid, lsu_resp_valid, mem_resp_ready, lsu_rdata);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    $display("txn reset during wait addr=80000400");
  endtask

  initial begin
    rst = 1'b0;
    ifu_req_valid = 1'b0; ifu_addr = 32'h0; ifu_resp_ready = 1'b1;
    lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_wen = 1'b0;
    lsu_wmask = 4'h0; lsu_resp_ready = 1'b1;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0; mem_resp_err = 1'b0;
    @(negedge clk);
    test_reset();
    test_ifu_read();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
